comma_word_aligner: RTL and testbench
=====================================

Name: comma_word_aligner

Overview:
- Downstream consumer of the CDR loop's recovered clock and retimed data.
- Runs on the phase-interpolated recovered clock and shifts in one retimed bit per cycle.
- Finds the 8b/10b K28.5 comma in either running disparity, fixes the 10-bit symbol boundary and emits aligned symbols with a strobe.
- Provides a hysteretic lock indication for the 8b/10b decoder and the link-status logic.

Parameters:
- COMMA_P, 10'h17C: K28.5 RD- pattern as held in the shift register (bit a in sr[0]).
- COMMA_N, 10'h283: K28.5 RD+ pattern, the bitwise complement of COMMA_P.
- LOCK_CNT, 3: number of consecutive boundary-aligned commas needed to declare lock (range 1..15).
- UNLOCK_CNT, 4: number of misaligned commas, with no aligned comma between them, needed to drop lock (range 1..15).

Ports:
- clk  in  1  Recovered PI clock; all logic is on its rising edge.
- rst_n  in  1  Reset, synchronous, active-low.
- Din  in  1  Retimed serial bit from the CDR; 8b/10b bit a arrives first.
- data_out  out  10  Aligned symbol; sr[0] = bit a, sr[9] = bit j.
- data_valid  out  1  One-cycle strobe; data_out is new in that cycle.
- comma_det  out  1  Qualifies data_valid: the emitted symbol equals COMMA_P or COMMA_N.
- locked  out  1  Alignment lock status.
- realign  out  1  One-cycle pulse when the symbol boundary is moved.

Behaviour:
- Reset (rst_n low at a rising edge), next state:
  - sr = 0, bit_cnt = 0, state = HUNT, good_cnt = 0, bad_cnt = 0.
  - All outputs = 0.
  - Applies mid-operation too; lock must be re-acquired from HUNT.
- Every cycle: sr_next = {Din, sr[9:1]}; sr <= sr_next.
- match = (sr_next == COMMA_P) or (sr_next == COMMA_N).
- bit_cnt is a 0..9 modulo counter. A boundary occurs when bit_cnt == 9; bit_cnt then wraps to 0.
- When a boundary occurs, or the realignment is forced as described below, at the same edge:
  - data_out <= sr_next
  - data_valid <= 1
  - comma_det <= match
- Otherwise data_valid, comma_det and realign are 0. data_out holds its value.
- Latency: data_valid is high in the cycle immediately after the edge that sampled the symbol's 10th bit.
- A forced realign sets bit_cnt <= 0 and raises realign for 1 cycle. If it coincides with bit_cnt == 9, it is still reported as a realign.
- State HUNT (locked = 0):
  - Boundaries come from the free-running bit_cnt.
  - On match: forced realign, good_cnt <= 1, go to VERIFY. If LOCK_CNT == 1, go directly to LOCKED.
- State VERIFY (locked = 0):
  - Aligned comma (match at bit_cnt == 9): good_cnt + 1. On reaching LOCK_CNT, go to LOCKED, good_cnt <= 0, and locked <= 1 at that same edge.
  - Misaligned comma (match at bit_cnt != 9): forced realign, good_cnt <= 1, stay in VERIFY.
  - Non-comma symbols: no effect.
- State LOCKED (locked = 1):
  - The boundary is never moved by a comma.
  - Aligned comma: bad_cnt <= 0.
  - Misaligned comma: bad_cnt + 1. On reaching UNLOCK_CNT: forced realign on that comma, good_cnt <= 1, bad_cnt <= 0, go to VERIFY, locked <= 0 at that edge.
- Counters saturate; they never wrap.
- RD- and RD+ commas are treated identically and may alternate freely.

Test Plan:
1. Reset: rst_n = 0 for 5 cycles with Din toggling.
   -> All outputs 0; first data_valid only at the 10th post-reset edge, with data_out containing the shifted bits.
2. Acquisition: 3 junk bits, then 0x17C serialized LSB-first.
   -> The cycle after its 10th bit: data_valid = 1, data_out = 0x17C, comma_det = 1, realign = 1, locked = 0.
3. Lock: continue from scenario 2 with 0x283 and 0x17C exactly 10 bits apart.
   -> locked = 1 in the data_valid cycle of the 3rd comma; realign stays 0; data_valid recurs every 10 clocks.
4. Data path while locked: send 0x17C, then D21.5 (0x2AA), D10.2 (0x155), and 16 random symbols.
   -> data_out reproduces each symbol in order, one data_valid per 10 clocks; comma_det = 1 only on commas.
5. Slip: while locked, drop one bit, then send 4 commas.
   -> locked stays 1 through 3 misaligned commas. On the 4th: locked = 0, realign = 1, data_out = comma. Lock returns after 2 more aligned commas.
6. Hysteresis and reset: in LOCKED, 3 misaligned commas, 1 aligned comma, 3 misaligned commas.
   -> locked never drops. Then rst_n low for 1 cycle -> locked = 0 next edge; full re-acquisition per scenario 3.

Source files
------------

// File: rtl/comma_word_aligner.sv
// K28.5 comma search and 10-bit symbol alignment on the recovered PI clock.
// Emits aligned symbols with a strobe and a hysteretic lock flag for the decoder.
module comma_word_aligner #(
  parameter logic [9:0]  COMMA_P    = 10'h17C,
  parameter logic [9:0]  COMMA_N    = 10'h283,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Din,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       comma_det,
  output logic       locked,
  output logic       realign
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_CNT);
  localparam logic [3:0] CNT_MAX   = 4'hF;
  localparam logic [3:0] LAST_BIT  = 4'd9;

  state_e     state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [3:0] bad_cnt_q, bad_cnt_d;
  logic [9:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       comma_det_q, comma_det_d;
  logic       realign_q, realign_d;
  logic       locked_q, locked_d;

  logic       match;
  logic       boundary;
  logic       force_align;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;

  // Shift path, comma compare and saturating counter increments.
  always_comb begin
    sr_d     = {Din, sr_q[9:1]};
    match    = (sr_d == COMMA_P) || (sr_d == COMMA_N);
    boundary = (bit_cnt_q == LAST_BIT);
    good_inc = (good_cnt_q == CNT_MAX) ? CNT_MAX : good_cnt_q + 4'd1;
    bad_inc  = (bad_cnt_q == CNT_MAX) ? CNT_MAX : bad_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    force_align = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (match) begin
          force_align = 1'b1;
          if (LOCK_CNT == 1) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            state_d    = VERIFY;
            good_cnt_d = 4'd1;
          end
        end
      end
      VERIFY: begin
        if (match) begin
          if (boundary) begin
            if (good_inc >= LOCK_TH) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_inc;
            end
          end else begin
            force_align = 1'b1;
            good_cnt_d  = 4'd1;
          end
        end
      end
      LOCKED: begin
        // Once locked, commas only vote; the boundary moves only after enough bad votes.
        if (match) begin
          if (boundary) begin
            bad_cnt_d = '0;
          end else if (bad_inc >= UNLOCK_TH) begin
            force_align = 1'b1;
            good_cnt_d  = 4'd1;
            bad_cnt_d   = '0;
            state_d     = VERIFY;
          end else begin
            bad_cnt_d = bad_inc;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_comb begin
    bit_cnt_d    = (boundary || force_align) ? 4'd0 : bit_cnt_q + 4'd1;
    data_valid_d = boundary || force_align;
    comma_det_d  = data_valid_d && match;
    realign_d    = force_align;
    data_out_d   = data_valid_d ? sr_d : data_out_q;
    locked_d     = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      comma_det_q  <= 1'b0;
      realign_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      comma_det_q  <= comma_det_d;
      realign_q    <= realign_d;
      locked_q     <= locked_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign comma_det  = comma_det_q;
  assign realign    = realign_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_comma_word_aligner.sv
// Bench for comma_word_aligner: directed link scenarios plus a random comma soak,
// checked every cycle against a boundary-anchor model of the aligner.
module tb_comma_word_aligner;

  localparam logic [9:0] COMMA_P    = 10'h17C;
  localparam logic [9:0] COMMA_N    = 10'h283;
  localparam int         LOCK_CNT   = 3;
  localparam int         UNLOCK_CNT = 4;
  localparam int         S_HUNT     = 0;
  localparam int         S_VERIFY   = 1;
  localparam int         S_LOCKED   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Din;
  logic [9:0] data_out;
  logic       data_valid;
  logic       comma_det;
  logic       locked;
  logic       realign;

  int testCount = 0;
  int failCount = 0;

  int         mCycle, mAnchor, mState, mGood, mBad;
  logic [9:0] mWindow;
  logic [9:0] expDout;
  logic       expValid, expComma, expRealign, expLocked;

  always #5 clk = ~clk;

  comma_word_aligner #(
    .COMMA_P(COMMA_P), .COMMA_N(COMMA_N),
    .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Din(Din),
    .data_out(data_out), .data_valid(data_valid), .comma_det(comma_det),
    .locked(locked), .realign(realign)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Boundaries are every 10th bit counted from the last reset or boundary move.
  task automatic modelEdge(input logic b, input logic r);
    logic isComma, onBoundary, move;
    if (!r) begin
      mCycle = 0; mAnchor = 0; mWindow = '0; mState = S_HUNT; mGood = 0; mBad = 0;
      expDout = '0; expValid = 1'b0; expComma = 1'b0; expRealign = 1'b0; expLocked = 1'b0;
      return;
    end
    mCycle++;
    mWindow    = {b, mWindow[9:1]};
    isComma    = (mWindow == COMMA_P) || (mWindow == COMMA_N);
    onBoundary = ((mCycle - mAnchor) % 10) == 0;
    move       = 1'b0;
    if (isComma) begin
      if (mState == S_HUNT) begin
        move = 1'b1;
        if (LOCK_CNT == 1) begin mState = S_LOCKED; mGood = 0; end
        else begin mState = S_VERIFY; mGood = 1; end
      end else if (mState == S_VERIFY) begin
        if (onBoundary) begin
          mGood = (mGood < 15) ? mGood + 1 : 15;
          if (mGood >= LOCK_CNT) begin mState = S_LOCKED; mGood = 0; end
        end else begin
          move = 1'b1; mGood = 1;
        end
      end else begin
        if (onBoundary) mBad = 0;
        else begin
          mBad = (mBad < 15) ? mBad + 1 : 15;
          if (mBad >= UNLOCK_CNT) begin
            move = 1'b1; mGood = 1; mBad = 0; mState = S_VERIFY;
          end
        end
      end
    end
    if (move) mAnchor = mCycle;
    expValid   = onBoundary || move;
    expRealign = move;
    expComma   = expValid && isComma;
    if (expValid) expDout = mWindow;
    expLocked  = (mState == S_LOCKED);
  endtask

  task automatic applyStimulus(input logic b, input logic r);
    @(negedge clk);
    Din   = b;
    rst_n = r;
    modelEdge(b, r);
    @(posedge clk);
    #1;
    checkOutput("data_valid", {15'd0, data_valid}, {15'd0, expValid});
    checkOutput("data_out",   {6'd0, data_out},    {6'd0, expDout});
    checkOutput("comma_det",  {15'd0, comma_det},  {15'd0, expComma});
    checkOutput("realign",    {15'd0, realign},    {15'd0, expRealign});
    checkOutput("locked",     {15'd0, locked},     {15'd0, expLocked});
  endtask

  task automatic sendSymbol(input logic [9:0] sym, input int nbits);
    for (int i = 0; i < nbits; i++) applyStimulus(sym[i], 1'b1);
  endtask

  task automatic expectStrobe(input string tag, input logic [9:0] sym, input logic rl, input logic lk);
    checkOutput({tag, "_valid"},   {15'd0, data_valid}, 16'd1);
    checkOutput({tag, "_dout"},    {6'd0, data_out},    {6'd0, sym});
    checkOutput({tag, "_comma"},   {15'd0, comma_det},  {15'd0, (sym == COMMA_P) || (sym == COMMA_N)});
    checkOutput({tag, "_realign"}, {15'd0, realign},    {15'd0, rl});
    checkOutput({tag, "_locked"},  {15'd0, locked},     {15'd0, lk});
  endtask

  function automatic logic hasComma(input logic [9:0] prev, input logic [9:0] cur);
    logic [19:0] both;
    both = {cur, prev};
    for (int k = 1; k <= 10; k++)
      if (both[k +: 10] == COMMA_P || both[k +: 10] == COMMA_N) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [9:0] prev, sym;
    int gap;
    Din   = 1'b0;
    rst_n = 1'b0;
    modelEdge(1'b0, 1'b0);

    // Reset with Din toggling, then first free-running boundary.
    for (int i = 0; i < 5; i++) applyStimulus(1'(i % 2), 1'b0);
    checkOutput("rst_locked", {15'd0, locked}, 16'd0);
    checkOutput("rst_dout", {6'd0, data_out}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'(i % 2), 1'b1);
      if (i < 9) checkOutput("rst_novalid", {15'd0, data_valid}, 16'd0);
    end
    expectStrobe("first", 10'h2AA, 1'b0, 1'b0);

    // Acquisition after 3 junk bits, then lock on the third comma.
    applyStimulus(1'b0, 1'b1); applyStimulus(1'b1, 1'b1); applyStimulus(1'b0, 1'b1);
    sendSymbol(COMMA_P, 10); expectStrobe("acq", COMMA_P, 1'b1, 1'b0);
    sendSymbol(COMMA_N, 10); expectStrobe("lock2", COMMA_N, 1'b0, 1'b0);
    sendSymbol(COMMA_P, 10); expectStrobe("lock3", COMMA_P, 1'b0, 1'b1);

    // Data path while locked.
    sendSymbol(COMMA_P, 10); expectStrobe("dp_k", COMMA_P, 1'b0, 1'b1);
    sendSymbol(10'h2AA, 10); expectStrobe("dp_d21", 10'h2AA, 1'b0, 1'b1);
    sendSymbol(10'h155, 10); expectStrobe("dp_d10", 10'h155, 1'b0, 1'b1);
    prev = 10'h155;
    for (int i = 0; i < 16; i++) begin
      do sym = 10'($urandom_range(0, 1023));
      while (sym == COMMA_P || sym == COMMA_N || hasComma(prev, sym));
      sendSymbol(sym, 10); expectStrobe("dp_rand", sym, 1'b0, 1'b1);
      prev = sym;
    end

    // Slip by one bit: three misaligned commas tolerated, the fourth realigns.
    sendSymbol(COMMA_P, 10); expectStrobe("slip_pre", COMMA_P, 1'b0, 1'b1);
    sendSymbol(10'h2AA, 9);
    for (int i = 0; i < 3; i++) begin
      sendSymbol((i % 2 == 0) ? COMMA_P : COMMA_N, 10);
      checkOutput("slip_hold_locked", {15'd0, locked}, 16'd1);
      checkOutput("slip_hold_valid", {15'd0, data_valid}, 16'd0);
    end
    sendSymbol(COMMA_N, 10); expectStrobe("slip_realign", COMMA_N, 1'b1, 1'b0);
    sendSymbol(COMMA_P, 10); expectStrobe("relock1", COMMA_P, 1'b0, 1'b0);
    sendSymbol(COMMA_N, 10); expectStrobe("relock2", COMMA_N, 1'b0, 1'b1);

    // Hysteresis: an aligned comma between bursts clears the bad count.
    sendSymbol(10'h2AA, 9);
    for (int i = 0; i < 3; i++) begin
      sendSymbol((i % 2 == 0) ? COMMA_P : COMMA_N, 10);
      checkOutput("hyst_a_locked", {15'd0, locked}, 16'd1);
    end
    applyStimulus(1'b0, 1'b1);
    sendSymbol(COMMA_N, 10); expectStrobe("hyst_aligned", COMMA_N, 1'b0, 1'b1);
    sendSymbol(10'h2AA, 9);
    for (int i = 0; i < 3; i++) begin
      sendSymbol((i % 2 == 0) ? COMMA_P : COMMA_N, 10);
      checkOutput("hyst_b_locked", {15'd0, locked}, 16'd1);
    end

    // Mid-operation reset and full re-acquisition.
    applyStimulus(1'b0, 1'b0);
    checkOutput("mid_rst_locked", {15'd0, locked}, 16'd0);
    checkOutput("mid_rst_valid", {15'd0, data_valid}, 16'd0);
    sendSymbol(COMMA_P, 10); expectStrobe("reacq1", COMMA_P, 1'b1, 1'b0);
    sendSymbol(COMMA_N, 10); expectStrobe("reacq2", COMMA_N, 1'b0, 1'b0);
    sendSymbol(COMMA_P, 10); expectStrobe("reacq3", COMMA_P, 1'b0, 1'b1);

    // Random soak: random gaps of noise bits between commas of either disparity.
    for (int it = 0; it < 90; it++) begin
      gap = int'($urandom_range(0, 24));
      for (int j = 0; j < gap; j++) applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      sendSymbol(($urandom_range(0, 1) == 0) ? COMMA_P : COMMA_N, 10);
      if (it == 45) applyStimulus(1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
